posit_acc_stream_es3: RTL and testbench



---
 rtl/posit_acc_stream_es3_if.sv | 38 +++
 rtl/posit_acc_stream_es3.sv | 151 +++++++++++++++
 tb/tb_posit_acc_stream_es3.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/posit_acc_stream_es3_if.sv
// ============================================================================
// posit_acc_stream_es3_if : input stream, adder bus and output stream bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface posit_acc_stream_es3_if #(
    parameter int NBITS = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [NBITS-1:0] in_data;
    logic             in_last;
    logic [NBITS-1:0] add_in1;
    logic [NBITS-1:0] add_in2;
    logic             add_start;
    logic [NBITS-1:0] add_result;
    logic             add_inf;
    logic             add_zero;
    logic             add_done;
    logic             out_valid;
    logic             out_ready;
    logic [NBITS-1:0] out_data;
    logic             out_inf;
    logic             out_zero;

    modport master (
        input  in_valid, in_data, in_last, add_result, add_inf, add_zero, add_done, out_ready,
        output in_ready, add_in1, add_in2, add_start, out_valid, out_data, out_inf, out_zero
    );

    modport slave (
        output in_valid, in_data, in_last, add_result, add_inf, add_zero, add_done, out_ready,
        input  in_ready, add_in1, add_in2, add_start, out_valid, out_data, out_inf, out_zero
    );
endinterface

`default_nettype wire

// File: rtl/posit_acc_stream_es3.sv
// ============================================================================
// posit_acc_stream_es3 : streaming posit reduction around a pipelined adder
// Optional beat counter port out_count when POSIT_ACC_STREAM_COUNT_EN is set.
// Rev 1.0
// ============================================================================
`default_nettype none

module posit_acc_stream_es3 #(
    parameter int NBITS       = 32,
    parameter int ADD_LATENCY = 4,
    parameter int CNT_W       = 3
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    posit_acc_stream_es3_if.master  bus
`ifdef POSIT_ACC_STREAM_COUNT_EN
    ,
    output logic [15:0]             out_count
`endif
);
    typedef enum logic [1:0] {
        S_FLUSH  = 2'd0,
        S_ACCUM  = 2'd1,
        S_REDUCE = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    localparam logic [NBITS-1:0] c_nar        = {1'b1, {(NBITS-1){1'b0}}};
    localparam logic [CNT_W-1:0] c_flush_last = CNT_W'(ADD_LATENCY - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_flush_cnt;
    logic [CNT_W-1:0]   r_inflight;
    logic [NBITS-1:0]   r_hold;
    logic               r_hold_zero;
    logic               r_hold_valid;
    logic               r_nar_sticky;

    logic               w_done;
    logic               w_accept;

    // Results arriving while flushing belong to a previous, abandoned stream.
    assign w_done   = bus.add_done && (r_state != S_FLUSH);
    assign w_accept = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= S_FLUSH;
            r_flush_cnt   <= '0;
            r_inflight    <= '0;
            r_hold        <= '0;
            r_hold_zero   <= 1'b0;
            r_hold_valid  <= 1'b0;
            r_nar_sticky  <= 1'b0;
            bus.in_ready  <= 1'b0;
            bus.add_start <= 1'b0;
            bus.add_in1   <= '0;
            bus.add_in2   <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_inf   <= 1'b0;
            bus.out_zero  <= 1'b0;
        end else begin
            bus.add_start <= 1'b0;
            r_inflight    <= r_inflight + CNT_W'(bus.add_start) - CNT_W'(w_done);
            if (w_done && bus.add_inf) begin
                r_nar_sticky <= 1'b1;
            end

            case (r_state)
                S_FLUSH: begin
                    if (r_flush_cnt == c_flush_last) begin
                        r_state      <= S_ACCUM;
                        bus.in_ready <= 1'b1;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + 1'b1;
                    end
                end

                S_ACCUM: begin
                    if (w_accept) begin
                        bus.add_start <= 1'b1;
                        bus.add_in1   <= bus.in_data;
                        bus.add_in2   <= w_done ? bus.add_result : '0;
                    end else if (w_done) begin
                        bus.add_start <= 1'b1;
                        bus.add_in1   <= bus.add_result;
                        bus.add_in2   <= '0;
                    end
                    if (w_accept && bus.in_last) begin
                        r_state      <= S_REDUCE;
                        bus.in_ready <= 1'b0;
                    end
                end

                S_REDUCE: begin
                    if (w_done) begin
                        if (!r_hold_valid) begin
                            r_hold       <= bus.add_result;
                            r_hold_zero  <= bus.add_zero;
                            r_hold_valid <= 1'b1;
                        end else begin
                            bus.add_start <= 1'b1;
                            bus.add_in1   <= bus.add_result;
                            bus.add_in2   <= r_hold;
                            r_hold_valid  <= 1'b0;
                        end
                    end else if (r_hold_valid && r_inflight == '0 && !bus.add_start) begin
                        // Only one partial remains and nothing is in the adder.
                        r_state       <= S_OUTPUT;
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= r_nar_sticky ? c_nar : r_hold;
                        bus.out_inf   <= r_nar_sticky;
                        bus.out_zero  <= !r_nar_sticky && r_hold_zero;
                    end
                end

                S_OUTPUT: begin
                    if (bus.out_ready) begin
                        r_state       <= S_ACCUM;
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        r_nar_sticky  <= 1'b0;
                        r_hold_valid  <= 1'b0;
                    end
                end

                default: r_state <= S_FLUSH;
            endcase
        end
    end

`ifdef POSIT_ACC_STREAM_COUNT_EN
    logic [15:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (r_state == S_OUTPUT && bus.out_ready) begin
            r_count <= '0;
        end else if (w_accept && r_count != 16'hFFFF) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign out_count = r_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_posit_acc_stream_es3.sv
// ============================================================================
// tb_posit_acc_stream_es3 : directed bench with a behavioural 4-cycle adder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_posit_acc_stream_es3;
    localparam int L = 4;
    localparam logic [31:0] NAR = 32'h8000_0000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   start_cnt = 0;

    always #5 clk = ~clk;

    posit_acc_stream_es3_if #(.NBITS(32)) bus ();

`ifdef POSIT_ACC_STREAM_COUNT_EN
    logic [15:0] out_count;
`endif

    posit_acc_stream_es3 #(.NBITS(32), .ADD_LATENCY(L), .CNT_W(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef POSIT_ACC_STREAM_COUNT_EN
        ,
        .out_count (out_count)
`endif
    );

    // Behavioural posit<32,3> arithmetic, valid for magnitudes in [1,256) and zero.
    function automatic real p2r(input logic [31:0] p);
        logic [31:0] m;
        real v;
        m = p[31] ? -p : p;
        if (p == 32'h0) return 0.0;
        v = (2.0 ** m[28:26]) * (1.0 + real'(m[25:0]) / 67108864.0);
        return p[31] ? -v : v;
    endfunction

    function automatic logic [31:0] r2p(input real v);
        real a;
        int e;
        logic [31:0] m;
        logic [25:0] f;
        if (v == 0.0) return 32'h0;
        a = (v < 0.0) ? -v : v;
        e = 0;
        while (a >= 2.0) begin
            a = a / 2.0;
            e++;
        end
        f = 26'($rtoi((a - 1.0) * 67108864.0));
        m = {1'b0, 2'b10, 3'(e), f};
        return (v < 0.0) ? -m : m;
    endfunction

    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
        if (a == NAR || b == NAR) return NAR;
        return r2p(p2r(a) + p2r(b));
    endfunction

    // Adder pipeline deliberately ignores reset so stale results must be discarded by the DUT.
    logic [L-1:0] pv = '0;
    logic [31:0]  pd [L] = '{default: 32'h0};

    always @(posedge clk) begin
        pv    <= {pv[L-2:0], bus.add_start};
        pd[0] <= model_add(bus.add_in1, bus.add_in2);
        for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
    end

    assign bus.add_done   = pv[L-1];
    assign bus.add_result = pd[L-1];
    assign bus.add_inf    = (pd[L-1] == NAR);
    assign bus.add_zero   = (pd[L-1] == 32'h0);

    always @(negedge clk) if (bus.add_start) start_cnt++;

    task automatic send_beat(input logic [31:0] d, input logic last);
        int n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            errors++;
            checks++;
            $display("FAIL in_ready_timeout: got %b expected 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_output();
        int n = 0;
        while (!bus.out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.out_valid) begin
            errors++;
            $display("FAIL out_valid_timeout: got %b expected 1", bus.out_valid);
        end
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.add_start, bus.out_valid, bus.out_inf, bus.out_zero} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {bus.in_ready, bus.add_start, bus.out_valid, bus.out_inf, bus.out_zero});
        end
        checks++;
        if ({bus.add_in1, bus.add_in2, bus.out_data} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {bus.add_in1, bus.add_in2, bus.out_data});
        end
        reset_n = 1'b1;
        for (int i = 1; i <= L; i++) begin
            @(negedge clk);
            checks++;
            if (bus.in_ready !== (i == L)) begin
                errors++;
                $display("FAIL flush_in_ready_%0d: got %b expected %b", i, bus.in_ready, (i == L));
            end
        end
    endtask

    task automatic test_single_beat();
        start_cnt = 0;
        send_beat(32'h4000_0000, 1'b1);
        wait_output();
        checks++;
        if (bus.out_data !== 32'h4000_0000 || bus.out_zero !== 1'b0 || bus.out_inf !== 1'b0) begin
            errors++;
            $display("FAIL single_beat: got %h z%b i%b expected 40000000 z0 i0",
                     bus.out_data, bus.out_zero, bus.out_inf);
        end
        checks++;
        if (start_cnt !== 1) begin
            errors++;
            $display("FAIL single_beat_starts: got %0d expected 1", start_cnt);
        end
`ifdef POSIT_ACC_STREAM_COUNT_EN
        checks++;
        if (out_count !== 16'd1) begin
            errors++;
            $display("FAIL single_beat_count: got %0d expected 1", out_count);
        end
`endif
        handshake();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_handshake: got v%b r%b expected v0 r1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        send_beat(32'h4000_0000, 1'b0);
        send_beat(32'h4400_0000, 1'b0);
        send_beat(32'h4800_0000, 1'b0);
        send_beat(32'h4C00_0000, 1'b1);
        wait_output();
        checks++;
        if (bus.out_data !== 32'h4F80_0000 || bus.out_zero !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back: got %h z%b expected 4f800000 z0", bus.out_data, bus.out_zero);
        end
        handshake();
    endtask

    task automatic test_gaps();
        int gaps [8] = '{0, 3, 1, 5, 0, 2, 6, 1};
        for (int i = 0; i < 8; i++) begin
            repeat (gaps[i]) @(negedge clk);
            send_beat(32'h4000_0000, i == 7);
        end
        wait_output();
        checks++;
        if (bus.out_data !== 32'h4C00_0000) begin
            errors++;
            $display("FAIL gaps_sum: got %h expected 4c000000", bus.out_data);
        end
`ifdef POSIT_ACC_STREAM_COUNT_EN
        checks++;
        if (out_count !== 16'd8) begin
            errors++;
            $display("FAIL gaps_count: got %0d expected 8", out_count);
        end
`endif
        handshake();
    endtask

    task automatic test_zero();
        send_beat(32'h4000_0000, 1'b0);
        send_beat(32'hC000_0000, 1'b1);
        wait_output();
        checks++;
        if (bus.out_data !== 32'h0 || bus.out_zero !== 1'b1 || bus.out_inf !== 1'b0) begin
            errors++;
            $display("FAIL zero_sum: got %h z%b i%b expected 00000000 z1 i0",
                     bus.out_data, bus.out_zero, bus.out_inf);
        end
        handshake();
    endtask

    task automatic test_nar();
        send_beat(32'h4000_0000, 1'b0);
        send_beat(NAR, 1'b0);
        send_beat(32'h4400_0000, 1'b1);
        wait_output();
        checks++;
        if (bus.out_data !== NAR || bus.out_inf !== 1'b1 || bus.out_zero !== 1'b0) begin
            errors++;
            $display("FAIL nar_sum: got %h i%b z%b expected 80000000 i1 z0",
                     bus.out_data, bus.out_inf, bus.out_zero);
        end
        handshake();
        send_beat(32'h4000_0000, 1'b1);
        wait_output();
        checks++;
        if (bus.out_data !== 32'h4000_0000 || bus.out_inf !== 1'b0) begin
            errors++;
            $display("FAIL nar_cleared: got %h i%b expected 40000000 i0", bus.out_data, bus.out_inf);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        int bad = 0;
        send_beat(32'h4800_0000, 1'b0);
        send_beat(32'h4400_0000, 1'b1);
        wait_output();
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h4A00_0000 || bus.in_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL backpressure_hold: got %0d unstable cycles expected 0", bad);
        end
        checks++;
        if (bus.out_data !== 32'h4A00_0000 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_final: got %h v%b expected 4a000000 v1", bus.out_data, bus.out_valid);
        end
        handshake();
    endtask

    task automatic test_reset_mid_reduce();
        send_beat(32'h4000_0000, 1'b0);
        send_beat(32'h4400_0000, 1'b0);
        send_beat(32'h4800_0000, 1'b1);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        checks++;
        if ({bus.in_ready, bus.add_start, bus.out_valid, bus.out_inf, bus.out_zero} !== 5'b0 ||
            {bus.add_in1, bus.add_in2, bus.out_data} !== 96'h0) begin
            errors++;
            $display("FAIL mid_reset_values: got r%b s%b v%b data %h expected all zero",
                     bus.in_ready, bus.add_start, bus.out_valid, {bus.add_in1, bus.add_in2, bus.out_data});
        end
        for (int i = 1; i <= L; i++) begin
            @(negedge clk);
            checks++;
            if (bus.in_ready !== (i == L)) begin
                errors++;
                $display("FAIL mid_reset_flush_%0d: got %b expected %b", i, bus.in_ready, (i == L));
            end
        end
        send_beat(32'h4400_0000, 1'b1);
        wait_output();
        checks++;
        if (bus.out_data !== 32'h4400_0000 || bus.out_inf !== 1'b0 || bus.out_zero !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_stream: got %h i%b z%b expected 44000000 i0 z0",
                     bus.out_data, bus.out_inf, bus.out_zero);
        end
        handshake();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'h0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_gaps();
        test_zero();
        test_nar();
        test_backpressure();
        test_reset_mid_reduce();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
